// File: rtl/sbit_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : sbit_pattern_gen
// Brief   : Framed S-bit test-pattern source, one trigger-unit word per VFAT
//           per bunch crossing (static / walking-one / PRBS-15 / counter).
// Revision: 1.0 - initial release
// ============================================================================
module sbit_pattern_gen #(
    parameter int NUM_VFATS = 24,
    parameter int TU_WIDTH  = 64,
    parameter int PERIOD_W  = 12,
    parameter int BURST_W   = 4,
    parameter int STAGGER   = 0
) (
    input  logic                          ttc_clk_40_i,
    input  logic                          reset_n_i,
    input  logic                          enable_i,
    input  logic                          bc0_i,
    input  logic [1:0]                    mode_i,
    input  logic [TU_WIDTH-1:0]           pattern_even_i,
    input  logic [TU_WIDTH-1:0]           pattern_odd_i,
    input  logic [PERIOD_W-1:0]           period_i,
    input  logic [BURST_W-1:0]            burst_len_i,
    input  logic [NUM_VFATS-1:0]          vfat_mask_i,
    input  logic [NUM_VFATS-1:0]          invert_i,
    output logic [NUM_VFATS*TU_WIDTH-1:0] sbits_o,
    output logic                          valid_o,
    output logic                          burst_start_o,
    output logic [15:0]                   burst_cnt_o
);

    localparam int REPS   = TU_WIDTH / 16;
    localparam int WALK_W = $clog2(TU_WIDTH);
    localparam int CMP_W  = (PERIOD_W > BURST_W) ? PERIOD_W : BURST_W;
    localparam logic [WALK_W-1:0]   WALK_LAST = WALK_W'(TU_WIDTH - 1);
    localparam logic [TU_WIDTH-1:0] WALK_ONE  = {{(TU_WIDTH-1){1'b0}}, 1'b1};

    logic [PERIOD_W-1:0]           pcnt_q, pcnt_d;
    logic [PERIOD_W:0]             pcnt_inc;
    logic [BURST_W-1:0]            scnt_q, scnt_d;
    logic                          first_q, first_d;
    logic [WALK_W-1:0]             walk_q, walk_d;
    logic [14:0]                   lfsr_q, lfsr_d;
    logic [15:0]                   dcnt_q, dcnt_d;
    logic [NUM_VFATS*TU_WIDTH-1:0] sbits_q, sbits_d;
    logic                          valid_q, valid_d;
    logic                          bstart_q, bstart_d;
    logic [15:0]                   bcnt_q, bcnt_d;

    logic [TU_WIDTH-1:0] base;
    logic [CMP_W-1:0]    pcnt_x, blen_x;
    logic                continuous;
    logic                active;
    logic                wrap;

    assign pcnt_x   = CMP_W'(pcnt_q);
    assign blen_x   = CMP_W'(burst_len_i);
    assign pcnt_inc = {1'b0, pcnt_q} + (PERIOD_W+1)'(1);

    always_comb begin
        continuous = (period_i == '0);
        wrap       = (pcnt_inc >= {1'b0, period_i});
        active     = 1'b0;
        bstart_d   = 1'b0;

        // In continuous mode the only burst boundary is the first cycle after enable/bc0.
        if (enable_i && (burst_len_i != '0)) begin
            if (continuous) begin
                active   = 1'b1;
                bstart_d = first_q;
            end else begin
                active   = (pcnt_x < blen_x);
                bstart_d = active && (pcnt_q == '0);
            end
        end

        pcnt_d  = pcnt_q;
        scnt_d  = scnt_q;
        first_d = first_q;
        if (!enable_i || bc0_i) begin
            pcnt_d  = '0;
            scnt_d  = '0;
            first_d = 1'b1;
        end else begin
            first_d = 1'b0;
            if (continuous) begin
                pcnt_d = '0;
                scnt_d = scnt_q + BURST_W'(1);
            end else begin
                pcnt_d = wrap ? '0 : pcnt_inc[PERIOD_W-1:0];
                scnt_d = pcnt_d[BURST_W-1:0];
            end
        end

        base   = '0;
        walk_d = walk_q;
        lfsr_d = lfsr_q;
        dcnt_d = dcnt_q;
        if (active) begin
            unique case (mode_i)
                2'd0: base = scnt_q[0] ? pattern_odd_i : pattern_even_i;
                2'd1: begin
                    base   = WALK_ONE << walk_q;
                    walk_d = (walk_q == WALK_LAST) ? '0 : walk_q + WALK_W'(1);
                end
                2'd2: begin
                    base   = {REPS{1'b0, lfsr_q}};
                    lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
                end
                default: begin
                    base   = {REPS{dcnt_q}};
                    dcnt_d = dcnt_q + 16'd1;
                end
            endcase
        end

        valid_d = active;
        bcnt_d  = (bstart_d && (bcnt_q != 16'hFFFF)) ? bcnt_q + 16'd1 : bcnt_q;
    end

    // Rotate, then mask, then invert: an idle inverted channel reads all ones.
    for (genvar n = 0; n < NUM_VFATS; n++) begin : g_chan
        localparam int ROT = (STAGGER != 0) ? (n % TU_WIDTH) : 0;
        logic [TU_WIDTH-1:0] rot_w;
        if (ROT == 0) begin : g_norot
            assign rot_w = base;
        end else begin : g_rot
            assign rot_w = {base[TU_WIDTH-1-ROT:0], base[TU_WIDTH-1:TU_WIDTH-ROT]};
        end
        assign sbits_d[n*TU_WIDTH +: TU_WIDTH] =
            (vfat_mask_i[n] ? {TU_WIDTH{1'b0}} : rot_w) ^ {TU_WIDTH{invert_i[n]}};
    end

    always_ff @(posedge ttc_clk_40_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pcnt_q   <= '0;
            scnt_q   <= '0;
            first_q  <= 1'b1;
            walk_q   <= '0;
            lfsr_q   <= 15'h7FFF;
            dcnt_q   <= '0;
            sbits_q  <= '0;
            valid_q  <= 1'b0;
            bstart_q <= 1'b0;
            bcnt_q   <= '0;
        end else begin
            pcnt_q   <= pcnt_d;
            scnt_q   <= scnt_d;
            first_q  <= first_d;
            walk_q   <= walk_d;
            lfsr_q   <= lfsr_d;
            dcnt_q   <= dcnt_d;
            sbits_q  <= sbits_d;
            valid_q  <= valid_d;
            bstart_q <= bstart_d;
            bcnt_q   <= bcnt_d;
        end
    end

    assign sbits_o       = sbits_q;
    assign valid_o       = valid_q;
    assign burst_start_o = bstart_q;
    assign burst_cnt_o   = bcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sbit_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_sbit_pattern_gen
// Brief   : Directed self-checking bench for sbit_pattern_gen (STAGGER=1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_sbit_pattern_gen;

    localparam int NV  = 24;
    localparam int TU  = 64;
    localparam int PW  = 12;
    localparam int BW  = 4;
    localparam int BUS = NV * TU;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           enable = 1'b0;
    logic           bc0   = 1'b0;
    logic [1:0]     mode  = 2'd0;
    logic [TU-1:0]  pat_e = '0;
    logic [TU-1:0]  pat_o = '0;
    logic [PW-1:0]  period = '0;
    logic [BW-1:0]  blen  = '0;
    logic [NV-1:0]  mask  = '0;
    logic [NV-1:0]  inv   = '0;
    logic [BUS-1:0] sbits;
    logic           valid;
    logic           bstart;
    logic [15:0]    bcnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sbit_pattern_gen #(
        .NUM_VFATS (NV),
        .TU_WIDTH  (TU),
        .PERIOD_W  (PW),
        .BURST_W   (BW),
        .STAGGER   (1)
    ) dut (
        .ttc_clk_40_i   (clk),
        .reset_n_i      (rst_n),
        .enable_i       (enable),
        .bc0_i          (bc0),
        .mode_i         (mode),
        .pattern_even_i (pat_e),
        .pattern_odd_i  (pat_o),
        .period_i       (period),
        .burst_len_i    (blen),
        .vfat_mask_i    (mask),
        .invert_i       (inv),
        .sbits_o        (sbits),
        .valid_o        (valid),
        .burst_start_o  (bstart),
        .burst_cnt_o    (bcnt)
    );

    function automatic logic [BUS-1:0] exp_bus(input logic [TU-1:0] b,
                                               input logic [NV-1:0] m,
                                               input logic [NV-1:0] iv);
        logic [BUS-1:0] r;
        logic [TU-1:0]  w;
        r = '0;
        for (int n = 0; n < NV; n++) begin
            w = (n == 0) ? b : ((b << n) | (b >> (TU - n)));
            if (m[n])  w = '0;
            if (iv[n]) w = ~w;
            r[n*TU +: TU] = w;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [TU-1:0] b, input logic ev,
                         input logic eb, input logic [15:0] ec);
        logic [BUS-1:0] e;
        int fc;
        e  = exp_bus(b, mask, inv);
        fc = 0;
        for (int n = NV - 1; n >= 0; n--)
            if (sbits[n*TU +: TU] !== e[n*TU +: TU]) fc = n;
        tests++;
        assert (sbits === e) else begin
            fails++;
            $error("FAIL %s sbits vfat%0d got %h expected %h", tag, fc, sbits[fc*TU +: TU], e[fc*TU +: TU]);
        end
        tests++;
        assert (valid === ev) else begin
            fails++;
            $error("FAIL %s valid got %b expected %b", tag, valid, ev);
        end
        tests++;
        assert (bstart === eb) else begin
            fails++;
            $error("FAIL %s burst_start got %b expected %b", tag, bstart, eb);
        end
        tests++;
        assert (bcnt === ec) else begin
            fails++;
            $error("FAIL %s burst_cnt got %h expected %h", tag, bcnt, ec);
        end
    endtask

    task automatic check_word(input string tag, input logic [TU-1:0] got, input logic [TU-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int slot;
        int p;
        logic [15:0] cnt;
        logic [14:0] l;
        logic [15:0] dc;
        logic [TU-1:0] b;

        #2 rst_n = 1'b0;
        #10;
        check("reset", '0, 1'b0, 1'b0, 16'd0);

        // Framed even/odd: period 16, burst 2
        pat_e = 64'h1; pat_o = 64'h2; period = 12'd16; blen = 4'd2; mode = 2'd0;
        rst_n = 1'b1; enable = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (k == 34) begin
                inv  = 24'h000001;
                mask = 24'h000002;
            end
            tick();
            slot = k % 16;
            b = (slot == 0) ? 64'h1 : ((slot == 1) ? 64'h2 : 64'h0);
            check(k < 34 ? "frame" : "inv_mask", b, slot < 2, slot == 0, 16'(k / 16 + 1));
            if (k == 40) check_word("vfat0_idle_ones", sbits[63:0], {64{1'b1}});
            if (k == 48) check_word("vfat1_masked", sbits[127:64], 64'h0);
            if (k == 48) check_word("vfat0_inverted", sbits[63:0], ~64'h1);
        end

        // Asynchronous reset while a burst slot is being presented
        rst_n = 1'b0; mask = '0; inv = '0;
        #1;
        check("async_rst", '0, 1'b0, 1'b0, 16'd0);

        // Walking one, continuous
        mode = 2'd1; period = '0; blen = 4'd2;
        rst_n = 1'b1;
        for (int k = 0; k < 65; k++) begin
            tick();
            check("walk", 64'h1 << (k % 64), 1'b1, k == 0, 16'd1);
            if (k == 0)  check_word("walk_vfat3_k0", sbits[255:192], 64'h8);
            if (k == 61) check_word("walk_vfat3_k61", sbits[255:192], 64'h1);
            if (k == 64) check_word("walk_wrap", sbits[63:0], 64'h1);
        end

        // PRBS-15, continuous
        rst_n = 1'b0; #1; rst_n = 1'b1;
        mode = 2'd2;
        l = 15'h7FFF;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("prbs", {4{1'b0, l}}, 1'b1, k == 0, 16'd1);
            if (k == 0) check_word("prbs_first", sbits[63:0], 64'h7FFF7FFF7FFF7FFF);
            if (k == 1) check_word("prbs_second", sbits[63:0], 64'h7FFE7FFE7FFE7FFE);
            l = {l[13:0], l[14] ^ l[13]};
        end

        // bc0 realign: period 100, burst 4; bc0 at pcnt 50 and again at pcnt 99
        rst_n = 1'b0; #1; rst_n = 1'b1;
        mode = 2'd0; period = 12'd100; blen = 4'd4;
        p = 0; cnt = 16'd0;
        for (int k = 0; k < 156; k++) begin
            bc0 = ((p == 50) && (k < 60)) || ((p == 99) && (k > 60));
            tick();
            if (p == 0) cnt = cnt + 16'd1;
            b = (p < 4) ? ((p % 2 == 1) ? 64'h2 : 64'h1) : 64'h0;
            check("bc0", b, p < 4, p == 0, cnt);
            if (k == 51) check_word("bc0_slot0", sbits[63:0], 64'h1);
            if (k == 151) check_word("bc0_wrap_slot0", sbits[63:0], 64'h1);
            p = (bc0 || (p == 99)) ? 0 : p + 1;
        end
        bc0 = 1'b0;

        // burst_len 0: never active
        blen = '0; period = 12'd16;
        for (int k = 0; k < 40; k++) begin
            tick();
            check("blen0", '0, 1'b0, 1'b0, cnt);
        end

        // Disabled: idle value carries inversion
        enable = 1'b0; blen = 4'd2; inv = 24'h000001;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("disabled", '0, 1'b0, 1'b0, cnt);
        end

        // Counter mode across the 0xFFFF -> 0x0000 wrap
        rst_n = 1'b0; #1; rst_n = 1'b1;
        inv = '0; enable = 1'b1; mode = 2'd3; period = '0; blen = 4'd4;
        dc = 16'd0;
        for (int k = 0; k < 65537; k++) begin
            tick();
            if (k < 3 || k > 65533) check("ctr", {4{dc}}, 1'b1, k == 0, 16'd1);
            if (k == 65535) check_word("ctr_ffff", sbits[63:0], 64'hFFFFFFFFFFFFFFFF);
            if (k == 65536) check_word("ctr_wrap", sbits[63:0], 64'h0);
            dc = dc + 16'd1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
